// File: rtl/turbo_frame_sched_if.sv
// Scheduler-side handshake bundle: rx FIFO read port, decoder enable/valid,
// tx FIFO status and the scheduler's status/error outputs.
interface turbo_frame_sched_if #(
  parameter int unsigned CNT_W = 16
);
  logic             rx_fifo_empty;
  logic             rx_fifo_rden;
  logic             dec_en;
  logic             dec_we;
  logic             tx_fifo_full;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;
  logic             ovf_err;
  logic             stray_err;
  logic             timeout;

  modport master (
    input  rx_fifo_empty, dec_we, tx_fifo_full,
    output rx_fifo_rden, dec_en, busy, frame_done, frame_cnt,
           ovf_err, stray_err, timeout
  );

  modport slave (
    output rx_fifo_empty, dec_we, tx_fifo_full,
    input  rx_fifo_rden, dec_en, busy, frame_done, frame_cnt,
           ovf_err, stray_err, timeout
  );
endinterface

// File: rtl/turbo_frame_sched.sv
// Turbo decoder frame scheduler: IDLE -> LOAD -> RUN -> GAP, one frame at a time.
// Optional LOAD+RUN watchdog abort enabled by defining TURBO_SCHED_WDOG_EN.
module turbo_frame_sched #(
  parameter int unsigned FRAME_WORDS = 260,
  parameter int unsigned OUT_WORDS   = 20,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned WDOG_CYCLES = 11000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk_dp,
  input  logic                clk_dp_rst_n,
  turbo_frame_sched_if.master bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_GAP} state_t;

  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_WORDS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic [CNT_W-1:0] gap_cnt_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             dec_en_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             ovf_q;
  logic             stray_q;
  logic             timeout_q;
  logic             rden;
  logic             last_out;

  assign rden     = (state_q == ST_LOAD) && !bus.rx_fifo_empty;
  assign last_out = (state_q == ST_RUN) && bus.dec_we && (out_cnt_q == OUT_LAST);

`ifdef TURBO_SCHED_WDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WDOG_CYCLES - 1);
  logic [CNT_W-1:0] wd_cnt_q;
`endif

  always_ff @(posedge clk_dp) begin
    if (!clk_dp_rst_n) begin
      state_q      <= ST_IDLE;
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      dec_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      stray_q      <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef TURBO_SCHED_WDOG_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      if (bus.dec_we && bus.tx_fifo_full) ovf_q <= 1'b1;
      if (bus.dec_we && (state_q != ST_RUN)) stray_q <= 1'b1;
`ifdef TURBO_SCHED_WDOG_EN
      if ((state_q == ST_LOAD) || (state_q == ST_RUN)) wd_cnt_q <= wd_cnt_q + 1'b1;
`endif

      unique case (state_q)
        ST_IDLE: begin
          if (!bus.rx_fifo_empty) begin
            state_q   <= ST_LOAD;
            dec_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
`ifdef TURBO_SCHED_WDOG_EN
            wd_cnt_q  <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (rden) begin
            if (rd_cnt_q == RD_LAST) begin
              state_q  <= ST_RUN;
              rd_cnt_q <= '0;
            end else begin
              rd_cnt_q <= rd_cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (last_out) begin
            state_q      <= ST_GAP;
            dec_en_q     <= 1'b0;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 1'b1;
            out_cnt_q    <= '0;
            gap_cnt_q    <= '0;
          end else if (bus.dec_we) begin
            out_cnt_q <= out_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

`ifdef TURBO_SCHED_WDOG_EN
      // Abort overrides the case above, except when the final word lands on the expiry edge.
      if (((state_q == ST_LOAD) || (state_q == ST_RUN)) && (wd_cnt_q == WD_LAST) && !last_out) begin
        state_q   <= ST_GAP;
        dec_en_q  <= 1'b0;
        timeout_q <= 1'b1;
        rd_cnt_q  <= '0;
        out_cnt_q <= '0;
        gap_cnt_q <= '0;
      end
`endif
    end
  end

  assign bus.rx_fifo_rden = rden;
  assign bus.dec_en       = dec_en_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_cnt    = frame_cnt_q;
  assign bus.ovf_err      = ovf_q;
  assign bus.stray_err    = stray_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_turbo_frame_sched.sv
// Randomized bench for turbo_frame_sched against a count-based frame model.
module tb_turbo_frame_sched;
  localparam int FW  = 260;
  localparam int OW  = 20;
  localparam int GAP = 16;
  localparam int WD  = 500;
  localparam int CW  = 16;
`ifdef TURBO_SCHED_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  turbo_frame_sched_if #(.CNT_W(CW)) bus ();

  turbo_frame_sched #(
    .FRAME_WORDS(FW), .OUT_WORDS(OW), .GAP_CYCLES(GAP), .WDOG_CYCLES(WD), .CNT_W(CW)
  ) dut (
    .clk_dp(clk),
    .clk_dp_rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: a frame is "active" while words are pulled or decoded; reads==FW means decoding.
  bit          m_active, m_done, m_to, m_ovf, m_stray;
  int          m_reads, m_outs, m_gap, m_el;
  int unsigned m_cnt;

  // {rden, dec_en, busy, frame_done, ovf, stray, timeout, frame_cnt}
  logic [CW+6:0] obs, expv;

  function automatic bit m_loading();
    return m_active && (m_reads < FW);
  endfunction

  function automatic bit m_running();
    return m_active && (m_reads == FW);
  endfunction

  function automatic logic [CW+6:0] model_out(input logic e);
    logic [CW-1:0] c;
    c = m_cnt[CW-1:0];
    return {m_loading() && !e, m_active, m_active || (m_gap > 0), m_done, m_ovf, m_stray, m_to, c};
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic w, input logic f);
    bit ld, rn, fin;
    if (!r) begin
      m_active = 0; m_reads = 0; m_outs = 0; m_gap = 0; m_el = 0; m_cnt = 0;
      m_ovf = 0; m_stray = 0; m_done = 0; m_to = 0;
    end else begin
      ld = m_loading();
      rn = m_running();
      m_done = 0;
      m_to = 0;
      if (w && f) m_ovf = 1;
      if (w && !rn) m_stray = 1;
      if (m_active) begin
        fin = rn && w && (m_outs == OW - 1);
        if (ld && !e) m_reads++;
        if (rn && w) m_outs++;
        m_el++;
        if (fin) begin
          m_active = 0; m_gap = GAP; m_done = 1; m_cnt = (m_cnt + 1) % (1 << CW);
        end else if (WD_ON && (m_el == WD)) begin
          m_active = 0; m_gap = GAP; m_to = 1;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (!e) begin
        m_active = 1; m_reads = 0; m_outs = 0; m_el = 0;
      end
    end
  endtask

  // One clock cycle: drive inputs, sample outputs and model prediction, then cross the edge.
  task automatic cyc(input logic r, input logic e, input logic w, input logic f);
    rst_n = r;
    bus.rx_fifo_empty = e;
    bus.dec_we = w;
    bus.tx_fifo_full = f;
    #1;
    obs  = {bus.rx_fifo_rden, bus.dec_en, bus.busy, bus.frame_done, bus.ovf_err,
            bus.stray_err, bus.timeout, bus.frame_cnt};
    expv = model_out(e);
    @(posedge clk);
    model_edge(r, e, w, f);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_seq got %h want %h", obs, expv); end
    end
  endtask

  // Drives one whole frame with an idealised decoder; lockstep-checks every cycle.
  task automatic run_frame(input int stall_at, input int ovf_at,
                           output int rc, output int dc, output int lc, output int wc);
    int  stall;
    bit  done, fin;
    logic e, w, f;
    rc = 0; dc = 0; lc = 0; wc = 0; stall = 0; done = 0; fin = 0;
    for (int g = 0; g < 3000; g++) begin
      if (done && !m_active && (m_gap == 0)) begin fin = 1; break; end
      e = done ? 1'b1 : (stall > 0);
      w = m_running() && ($urandom_range(0, 1) == 1);
      f = w && (wc == ovf_at);
      cyc(1'b1, e, w, f);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL frame_cycle %0d got %h want %h", g, obs, expv); end
      if (stall > 0) stall--;
      if (obs[CW+6]) begin rc++; if (rc == stall_at) stall = 5; end
      if (obs[CW+3]) begin dc++; done = 1; end
      if (obs[CW+4] && !obs[CW+5]) lc++;
      if (w) wc++;
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL frame_bound got unfinished want finished"); end
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs); end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_release got %h want %h", obs, expv); end
    end
    checks++;
    if (obs[CW+6] !== 1'b1) begin errors++; $display("FAIL first_rden got %b want 1", obs[CW+6]); end
  endtask

  task automatic test_normal_frame();
    int rc, dc, lc, wc;
    do_reset();
    run_frame(-1, -1, rc, dc, lc, wc);
    checks++;
    if (rc != FW) begin errors++; $display("FAIL normal_rden got %0d want %0d", rc, FW); end
    checks++;
    if (dc != 1) begin errors++; $display("FAIL normal_done got %0d want 1", dc); end
    checks++;
    if (obs[CW-1:0] !== 16'd1) begin errors++; $display("FAIL normal_cnt got %0d want 1", obs[CW-1:0]); end
    checks++;
    if (lc != GAP) begin errors++; $display("FAIL normal_gap got %0d want %0d", lc, GAP); end
  endtask

  task automatic test_stall();
    int rc, dc, lc, wc;
    do_reset();
    run_frame(100, -1, rc, dc, lc, wc);
    checks++;
    if (rc != FW) begin errors++; $display("FAIL stall_rden got %0d want %0d", rc, FW); end
    checks++;
    if (dc != 1) begin errors++; $display("FAIL stall_done got %0d want 1", dc); end
  endtask

  task automatic test_errors();
    int rc, dc, lc, wc;
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs[CW+2:CW+1] !== 2'b01) begin errors++; $display("FAIL stray_idle got %b want 01", obs[CW+2:CW+1]); end
    run_frame(-1, 3, rc, dc, lc, wc);
    checks++;
    if (obs[CW+2:CW+1] !== 2'b11) begin errors++; $display("FAIL ovf_run got %b want 11", obs[CW+2:CW+1]); end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL err_hold got %h want %h", obs, expv); end
    end
    checks++;
    if (obs[CW+2:CW+1] !== 2'b11) begin errors++; $display("FAIL err_sticky got %b want 11", obs[CW+2:CW+1]); end
    do_reset();
    checks++;
    if (obs[CW+2:CW+1] !== 2'b00) begin errors++; $display("FAIL err_clear got %b want 00", obs[CW+2:CW+1]); end
  endtask

  task automatic test_watchdog();
    int rc, to_cnt, pulse_at;
    rc = 0; to_cnt = 0; pulse_at = -1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(1'b1, (rc >= FW), 1'b0, 1'b0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL wdog_cycle %0d got %h want %h", i, obs, expv); end
      if (obs[CW+6]) rc++;
      if (obs[CW]) begin to_cnt++; pulse_at = i; end
    end
    checks++;
    if (to_cnt != (WD_ON ? 1 : 0)) begin errors++; $display("FAIL wdog_pulses got %0d want %0d", to_cnt, WD_ON ? 1 : 0); end
    checks++;
    if (WD_ON && (pulse_at != WD + 1)) begin errors++; $display("FAIL wdog_time got %0d want %0d", pulse_at, WD + 1); end
    checks++;
    if (obs[CW+5:CW+4] !== (WD_ON ? 2'b00 : 2'b11)) begin
      errors++; $display("FAIL wdog_state got %b want %b", obs[CW+5:CW+4], WD_ON ? 2'b00 : 2'b11);
    end
    checks++;
    if (obs[CW-1:0] !== '0) begin errors++; $display("FAIL wdog_cnt got %0d want 0", obs[CW-1:0]); end
  endtask

  task automatic test_reset_mid_run();
    int rc, dc, lc, wc, sent;
    bit w;
    rc = 0; sent = 0;
    do_reset();
    for (int i = 0; i < 1000 && sent < 7; i++) begin
      w = m_running() && ($urandom_range(0, 1) == 1);
      cyc(1'b1, (rc >= FW), w, 1'b0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL midrun_cycle %0d got %h want %h", i, obs, expv); end
      if (obs[CW+6]) rc++;
      if (w) sent++;
    end
    do_reset();
    run_frame(-1, -1, rc, dc, lc, wc);
    checks++;
    if (wc != OW) begin errors++; $display("FAIL midrun_words got %0d want %0d", wc, OW); end
    checks++;
    if (obs[CW-1:0] !== 16'd1) begin errors++; $display("FAIL midrun_cnt got %0d want 1", obs[CW-1:0]); end
  endtask

  task automatic test_random();
    logic e, w, f;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      e = ($urandom_range(0, 7) == 0);
      w = m_running() ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 40) == 0);
      f = ($urandom_range(0, 15) == 0);
      cyc(1'b1, e, w, f);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random_cycle %0d got %h want %h", i, obs, expv); end
    end
  endtask

  initial begin
    bus.rx_fifo_empty = 1'b1;
    bus.dec_we = 1'b0;
    bus.tx_fifo_full = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_normal_frame();
    test_stall();
    test_errors();
    test_watchdog();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
